// File: rtl/fp16_raddsub_issue_if.sv
// Issue/return bundle between an operand producer, the issue stage and the
// external pipelined FP16 adder, plus the result stream towards the consumer.
interface fp16_raddsub_issue_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_x;
  logic [15:0] in_y;
  logic        in_is_sub;
  logic [15:0] add_arg_0;
  logic [15:0] add_arg_1;
  logic        add_arg_2;
  logic [15:0] add_ret;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        busy;

  modport master (
    output in_valid, in_x, in_y, in_is_sub, add_ret, out_ready,
    input  in_ready, add_arg_0, add_arg_1, add_arg_2, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_x, in_y, in_is_sub, add_ret, out_ready,
    output in_ready, add_arg_0, add_arg_1, add_arg_2, out_valid, out_data, busy
  );
endinterface

// File: rtl/fp16_raddsub_issue.sv
// Issue stage for an external LATENCY-deep FP16 add/sub pipe with an in-order result buffer.
// Optional FP16_RADDSUB_ISSUE_FTZ_EN: subnormal operands are flushed to signed zero on issue.
module fp16_raddsub_issue #(
  parameter int LATENCY    = 5,
  parameter int FIFO_DEPTH = 8
) (
  input logic                 clk,
  input logic                 rst,
  fp16_raddsub_issue_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [CNT_W:0]   sum_t;

  localparam ptr_t PTR_ONE   = ptr_t'(1'b1);
  localparam ptr_t PTR_ZERO  = ptr_t'(1'b0);
  localparam cnt_t CNT_ONE   = cnt_t'(1'b1);
  localparam cnt_t CNT_ZERO  = cnt_t'(1'b0);
  localparam sum_t DEPTH_SUM = sum_t'(FIFO_DEPTH);

  function automatic logic [15:0] flush_subnormal(input logic [15:0] op);
`ifdef FP16_RADDSUB_ISSUE_FTZ_EN
    if (op[14:10] == 5'd0) begin
      return {op[15], 15'd0};
    end else begin
      return op;
    end
`else
    return op;
`endif
  endfunction

  logic [15:0]         arg_x_r;
  logic [15:0]         arg_y_r;
  logic                arg_sub_r;
  logic [LATENCY-1:0]  vld_sr_r;
  logic [LATENCY-1:0]  vld_sr_nxt_s;
  cnt_t                inflight_r;
  cnt_t                inflight_nxt_s;
  cnt_t                count_r;
  cnt_t                count_nxt_s;
  ptr_t                wr_ptr_r;
  ptr_t                wr_ptr_nxt_s;
  ptr_t                rd_ptr_r;
  ptr_t                rd_ptr_nxt_s;
  logic [15:0]         fifo_mem_r [FIFO_DEPTH];
  logic [15:0]         head_nxt_s;
  logic                in_ready_r;
  logic                out_valid_r;
  logic [15:0]         out_data_r;
  logic                busy_r;
  logic                fire_s;
  logic                push_s;
  logic                pop_s;

  assign fire_s = bus.in_valid && in_ready_r;
  assign push_s = vld_sr_r[LATENCY-1];
  assign pop_s  = out_valid_r && bus.out_ready;

  // Valid pipe next state: a fire enters at bit 0 and leaves LATENCY edges later.
  always_comb begin
    vld_sr_nxt_s    = vld_sr_r;
    vld_sr_nxt_s[0] = fire_s;
    for (int i = 1; i < LATENCY; i++) begin
      vld_sr_nxt_s[i] = vld_sr_r[i-1];
    end
  end

  // Occupancy, pointers and the head entry as they will be after this edge.
  always_comb begin
    inflight_nxt_s = inflight_r;
    count_nxt_s    = count_r;
    wr_ptr_nxt_s   = wr_ptr_r;
    rd_ptr_nxt_s   = rd_ptr_r;
    head_nxt_s     = fifo_mem_r[rd_ptr_r];

    if (fire_s && !push_s) begin
      inflight_nxt_s = inflight_r + CNT_ONE;
    end else if (!fire_s && push_s) begin
      inflight_nxt_s = inflight_r - CNT_ONE;
    end else begin
      inflight_nxt_s = inflight_r;
    end

    if (push_s && !pop_s) begin
      count_nxt_s = count_r + CNT_ONE;
    end else if (!push_s && pop_s) begin
      count_nxt_s = count_r - CNT_ONE;
    end else begin
      count_nxt_s = count_r;
    end

    if (push_s) begin
      wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
    end else begin
      wr_ptr_nxt_s = wr_ptr_r;
    end

    if (pop_s) begin
      rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end

    // A push landing on the new head slot is not in the array yet; bypass it.
    if (push_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
      head_nxt_s = bus.add_ret;
    end else begin
      head_nxt_s = fifo_mem_r[rd_ptr_nxt_s];
    end
  end

  // Operand registers feeding adder stage 0; they only move on a fire.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      arg_x_r   <= 16'd0;
      arg_y_r   <= 16'd0;
      arg_sub_r <= 1'b0;
    end else if (fire_s) begin
      arg_x_r   <= flush_subnormal(bus.in_x);
      arg_y_r   <= flush_subnormal(bus.in_y);
      arg_sub_r <= bus.in_is_sub;
    end
  end

  // Tracking state, result buffer and the registered status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_sr_r    <= '0;
      inflight_r  <= CNT_ZERO;
      count_r     <= CNT_ZERO;
      wr_ptr_r    <= PTR_ZERO;
      rd_ptr_r    <= PTR_ZERO;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      out_data_r  <= 16'd0;
      busy_r      <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_r[i] <= 16'd0;
      end
    end else begin
      vld_sr_r    <= vld_sr_nxt_s;
      inflight_r  <= inflight_nxt_s;
      count_r     <= count_nxt_s;
      wr_ptr_r    <= wr_ptr_nxt_s;
      rd_ptr_r    <= rd_ptr_nxt_s;
      // Credit check counts in-flight pairs so every issued pair has a slot waiting.
      in_ready_r  <= (sum_t'(inflight_nxt_s) + sum_t'(count_nxt_s)) < DEPTH_SUM;
      out_valid_r <= (count_nxt_s != CNT_ZERO);
      out_data_r  <= head_nxt_s;
      busy_r      <= (inflight_nxt_s != CNT_ZERO) || (count_nxt_s != CNT_ZERO);
      if (push_s) begin
        fifo_mem_r[wr_ptr_r] <= bus.add_ret;
      end
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.add_arg_0 = arg_x_r;
  assign bus.add_arg_1 = arg_y_r;
  assign bus.add_arg_2 = arg_sub_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.busy      = busy_r;
endmodule

// File: tb/tb_fp16_raddsub_issue.sv
// Bench for fp16_raddsub_issue: a behavioural LATENCY-deep adder model on add_arg/add_ret,
// a table of directed vectors and hand-written sequences for backpressure, reset and wrap.
module tb_fp16_raddsub_issue;
  localparam int LAT   = 5;
  localparam int DEPTH = 8;
`ifdef FP16_RADDSUB_ISSUE_FTZ_EN
  localparam bit FTZ = 1'b1;
`else
  localparam bit FTZ = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fp16_raddsub_issue_if bus ();

  fp16_raddsub_issue #(.LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  int pops   = 0;
  logic [15:0] sb [$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // External adder model: real sums for the known pairs, an order-revealing tag otherwise.
  function automatic logic [15:0] adder_model(input logic [15:0] x, input logic [15:0] y, input logic s);
    case ({x, y, s})
      {16'h3C00, 16'h3C00, 1'b0}: return 16'h4000;
      {16'h4000, 16'h3C00, 1'b1}: return 16'h3C00;
      default:                    return x ^ {y[7:0], y[15:8]} ^ {15'd0, s};
    endcase
  endfunction

  function automatic logic [15:0] ftz(input logic [15:0] op);
    if (FTZ && (op[14:10] == 5'd0)) return {op[15], 15'd0};
    else return op;
  endfunction

  logic [15:0] pipe [LAT-1];
  always @(posedge clk) begin
    pipe[0] <= adder_model(bus.add_arg_0, bus.add_arg_1, bus.add_arg_2);
    for (int i = 1; i < LAT-1; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.add_ret = pipe[LAT-2];

  // Scoreboard: record on accept, compare on pop, both sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      if (bus.in_valid && bus.in_ready)
        sb.push_back(adder_model(ftz(bus.in_x), ftz(bus.in_y), bus.in_is_sub));
      if (bus.out_valid && bus.out_ready) begin
        pops++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_extra_pop: got %h, expected no result", bus.out_data);
        end else begin
          chk("sb_order", bus.out_data, sb.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    bus.out_ready = 1'b1;
    while (bus.busy && n < budget) begin
      tick();
      n++;
    end
    if (bus.busy) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: busy still 1 after %0d cycles, expected 0", budget);
    end
  endtask

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic        sub;
    logic [15:0] a0;
    logic [15:0] a1;
    logic [15:0] res;
  } vec_t;

  vec_t vecs [5];
  logic [15:0] b2b_x [4];
  logic [15:0] b2b_y [4];
  logic        b2b_s [4];
  logic [15:0] b2b_r [4];
  int base;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{16'h3C00, 16'h3C00, 1'b0, 16'h3C00, 16'h3C00, 16'h4000};
    vecs[1] = '{16'h4000, 16'h3C00, 1'b1, 16'h4000, 16'h3C00, 16'h3C00};
    vecs[2] = '{16'h0001, 16'h0000, 1'b0, FTZ ? 16'h0000 : 16'h0001, 16'h0000,
                FTZ ? 16'h0000 : 16'h0001};
    vecs[3] = '{16'h3C00, 16'h8201, 1'b1, 16'h3C00, FTZ ? 16'h8000 : 16'h8201,
                FTZ ? 16'h3C81 : 16'h3D83};
    vecs[4] = '{16'h4A00, 16'hC500, 1'b0, 16'h4A00, 16'hC500, 16'h4AC5};
    b2b_x = '{16'h3C00, 16'h4000, 16'h4800, 16'h5000};
    b2b_y = '{16'h3C00, 16'h3C00, 16'h4400, 16'h3400};
    b2b_s = '{1'b0, 1'b1, 1'b0, 1'b1};
    b2b_r = '{16'h4000, 16'h3C00, 16'h4844, 16'h5035};

    bus.in_valid  = 1'b0;
    bus.in_x      = 16'h0000;
    bus.in_y      = 16'h0000;
    bus.in_is_sub = 1'b0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    #2 rst = 1'b0;
    #10;
    chk("rst_in_ready", {15'd0, bus.in_ready}, 16'h0000);
    chk("rst_out_valid", {15'd0, bus.out_valid}, 16'h0000);
    chk("rst_out_data", bus.out_data, 16'h0000);
    chk("rst_busy", {15'd0, bus.busy}, 16'h0000);
    chk("rst_arg0", bus.add_arg_0, 16'h0000);
    @(posedge clk);
    #1 rst = 1'b1;
    chk("ready_before_edge", {15'd0, bus.in_ready}, 16'h0000);
    tick();
    chk("ready_after_release", {15'd0, bus.in_ready}, 16'h0001);

    // Single-pair vectors: operand capture, exact latency and data.
    bus.out_ready = 1'b1;
    for (int v = 0; v < 5; v++) begin
      bus.in_valid  = 1'b1;
      bus.in_x      = vecs[v].x;
      bus.in_y      = vecs[v].y;
      bus.in_is_sub = vecs[v].sub;
      tick();
      bus.in_valid  = 1'b0;
      bus.in_x      = 16'hFFFF;
      chk($sformatf("v%0d_arg0", v), bus.add_arg_0, vecs[v].a0);
      chk($sformatf("v%0d_arg1", v), bus.add_arg_1, vecs[v].a1);
      chk($sformatf("v%0d_arg2", v), {15'd0, bus.add_arg_2}, {15'd0, vecs[v].sub});
      repeat (LAT-1) tick();
      chk($sformatf("v%0d_early_valid", v), {15'd0, bus.out_valid}, 16'h0000);
      tick();
      chk($sformatf("v%0d_valid", v), {15'd0, bus.out_valid}, 16'h0001);
      chk($sformatf("v%0d_data", v), bus.out_data, vecs[v].res);
      chk($sformatf("v%0d_arg0_hold", v), bus.add_arg_0, vecs[v].a0);
      tick();
      chk($sformatf("v%0d_idle", v), {15'd0, bus.busy}, 16'h0000);
    end

    // Four back-to-back fires return on four consecutive cycles in order.
    for (int i = 0; i < 4; i++) begin
      bus.in_valid  = 1'b1;
      bus.in_x      = b2b_x[i];
      bus.in_y      = b2b_y[i];
      bus.in_is_sub = b2b_s[i];
      tick();
    end
    bus.in_valid = 1'b0;
    tick();
    chk("b2b_not_yet", {15'd0, bus.out_valid}, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("b2b_valid%0d", i), {15'd0, bus.out_valid}, 16'h0001);
      chk($sformatf("b2b_data%0d", i), bus.out_data, b2b_r[i]);
    end
    tick();
    chk("b2b_done", {15'd0, bus.out_valid}, 16'h0000);

    // Backpressure: eight fires fill every credit, one pop frees exactly one.
    bus.out_ready = 1'b0;
    base = pops;
    for (int i = 0; i < 8; i++) begin
      bus.in_valid  = 1'b1;
      bus.in_x      = 16'h4400 + 16'(i);
      bus.in_y      = 16'h3800;
      bus.in_is_sub = i[0];
      if (i == 7) chk("ready_at_7", {15'd0, bus.in_ready}, 16'h0001);
      tick();
    end
    chk("ready_full", {15'd0, bus.in_ready}, 16'h0000);
    bus.in_x = 16'h4500;
    repeat (6) tick();
    chk("ready_full_held", {15'd0, bus.in_ready}, 16'h0000);
    chk("full_valid", {15'd0, bus.out_valid}, 16'h0001);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("ready_after_pop", {15'd0, bus.in_ready}, 16'h0001);
    tick();
    bus.in_valid = 1'b0;
    chk("ready_refull", {15'd0, bus.in_ready}, 16'h0000);
    drain(60);
    chk("bp_pop_count", 16'(pops - base), 16'd9);
    chk("bp_sb_empty", 16'(sb.size()), 16'd0);

    // Push and pop on the same edge with seven entries buffered.
    bus.out_ready = 1'b0;
    base = pops;
    for (int i = 0; i < 7; i++) begin
      bus.in_valid  = 1'b1;
      bus.in_x      = 16'h5400 + 16'(i);
      bus.in_y      = 16'h3000;
      bus.in_is_sub = 1'b0;
      tick();
    end
    bus.in_valid = 1'b0;
    repeat (LAT) tick();
    chk("cnt7_ready", {15'd0, bus.in_ready}, 16'h0001);
    bus.in_valid = 1'b1;
    bus.in_x     = 16'h5800;
    tick();
    bus.in_valid = 1'b0;
    chk("cnt7_fire_full", {15'd0, bus.in_ready}, 16'h0000);
    repeat (LAT-1) tick();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("pushpop_ready", {15'd0, bus.in_ready}, 16'h0001);
    drain(60);
    chk("pushpop_pop_count", 16'(pops - base), 16'd8);

    // Twenty pairs streamed at full rate wrap the pointers more than twice.
    base = pops;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 25; i++) begin
      if (i < 20) begin
        bus.in_valid  = 1'b1;
        bus.in_x      = 16'h6000 + 16'(i * 3);
        bus.in_y      = 16'h2C00 + 16'(i);
        bus.in_is_sub = i[1];
      end else begin
        bus.in_valid = 1'b0;
      end
      tick();
      if (i >= LAT) chk($sformatf("stream_valid%0d", i), {15'd0, bus.out_valid}, 16'h0001);
    end
    tick();
    chk("stream_end", {15'd0, bus.out_valid}, 16'h0000);
    chk("stream_pop_count", 16'(pops - base), 16'd20);

    // Reset two cycles after three fires discards everything in flight.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_x     = 16'h4C00 + 16'(i);
      bus.in_y     = 16'h4C00;
      tick();
    end
    bus.in_valid = 1'b0;
    repeat (2) tick();
    chk("pre_rst_busy", {15'd0, bus.busy}, 16'h0001);
    rst = 1'b0;
    #1;
    chk("async_in_ready", {15'd0, bus.in_ready}, 16'h0000);
    chk("async_out_valid", {15'd0, bus.out_valid}, 16'h0000);
    chk("async_out_data", bus.out_data, 16'h0000);
    chk("async_busy", {15'd0, bus.busy}, 16'h0000);
    chk("async_arg0", bus.add_arg_0, 16'h0000);
    chk("async_arg1", bus.add_arg_1, 16'h0000);
    sb.delete();
    repeat (2) tick();
    rst = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("post_rst_valid%0d", i), {15'd0, bus.out_valid}, 16'h0000);
      if (i == 0) chk("post_rst_ready", {15'd0, bus.in_ready}, 16'h0001);
    end
    chk("post_rst_busy", {15'd0, bus.busy}, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
